// File: rtl/sdram_cpu_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sdram_cpu_port
//  Description : Bridge between an 8-bit CPU bus and one 16-bit toggle-
//                handshake port of the dual-port SDRAM controller. It posts
//                one write, queues one more access behind it, and keeps a
//                one-word write-through read cache.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        system / SDRAM clock, rising edge
//    reset      synchronous active-high reset
//    cpu_rd     one-cycle read strobe (ignored while cpu_busy)
//    cpu_wr     one-cycle write strobe (ignored while cpu_busy)
//    cpu_a      byte address, sampled with the strobe
//    cpu_din    write byte, sampled with the strobe
//    cpu_dout   read byte, held until the next read completes
//    cpu_busy   1 = strobes are ignored
//    cache_inv  pulse: drop the cached word
//    port_req   toggle request to the controller
//    port_ack   controller acknowledge (done when port_ack == port_req)
//    port_we    1 = write
//    port_a     word address
//    port_ds    byte enables, [1] upper / [0] lower
//    port_d     write data
//    port_q     read data, valid on the ack cycle
// ============================================================================
module sdram_cpu_port #(
    parameter int ADDR_W   = 24,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_busy,
    input  logic              cache_inv,
    output logic              port_req,
    input  logic              port_ack,
    output logic              port_we,
    output logic [ADDR_W-2:0] port_a,
    output logic [1:0]        port_ds,
    output logic [15:0]       port_d,
    input  logic [15:0]       port_q
);

    typedef enum logic [1:0] {
        S_DRAIN   = 2'd0,
        S_IDLE    = 2'd1,
        S_WR_WAIT = 2'd2,
        S_RD_WAIT = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_req;
    logic                r_we;
    logic [ADDR_W-2:0]   r_a;
    logic [1:0]          r_ds;
    logic [15:0]         r_d;
    logic [7:0]          r_dout;
    logic                r_busy;
    logic                r_cvalid;
    logic [ADDR_W-2:0]   r_ctag;
    logic [15:0]         r_cdata;
    logic                r_pv;
    logic                r_pwe;
    logic [ADDR_W-1:0]   r_pa;
    logic [7:0]          r_pdin;

    logic                w_ack_eq;
    logic                w_rd;
    logic                w_wr;
    logic                w_tag_match;
    logic                w_hit;
    logic                w_cpu_req;
    logic [7:0]          w_cache_byte;
    logic                w_issue;
    logic                w_iss_we;
    logic [ADDR_W-1:0]   w_iss_a;
    logic [7:0]          w_iss_din;

    assign w_ack_eq     = (port_ack == r_req);
    assign w_rd         = cpu_rd & ~r_busy;
    assign w_wr         = cpu_wr & ~r_busy;
    assign w_tag_match  = r_cvalid && (r_ctag == cpu_a[ADDR_W-1:1]);
    // An invalidate arriving with the read makes it a miss.
    assign w_hit        = CACHE_EN && w_rd && w_tag_match && !cache_inv;
    assign w_cpu_req    = (w_rd && !w_hit) || w_wr;
    assign w_cache_byte = cpu_a[0] ? r_cdata[15:8] : r_cdata[7:0];

    // Selects what (if anything) goes onto the port this edge: the fresh CPU
    // access from IDLE, or on a write ack either the pending access or a
    // strobe arriving on that same edge.
    always_comb begin
        w_issue   = 1'b0;
        w_iss_we  = 1'b0;
        w_iss_a   = cpu_a;
        w_iss_din = cpu_din;
        case (r_state)
            S_IDLE: begin
                if (w_cpu_req) begin
                    w_issue  = 1'b1;
                    w_iss_we = w_wr;
                end
            end
            S_WR_WAIT: begin
                if (w_ack_eq) begin
                    if (r_pv) begin
                        w_issue   = 1'b1;
                        w_iss_we  = r_pwe;
                        w_iss_a   = r_pa;
                        w_iss_din = r_pdin;
                    end else if (w_cpu_req) begin
                        w_issue  = 1'b1;
                        w_iss_we = w_wr;
                    end
                end
            end
            default: begin
                w_issue = 1'b0;
            end
        endcase
    end

    // port_req and the request fields are left out of reset on purpose: a
    // transaction in flight across reset must stay stable and must not see
    // a spurious toggle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_DRAIN;
            r_busy   <= 1'b1;
            r_dout   <= 8'hFF;
            r_cvalid <= 1'b0;
            r_pv     <= 1'b0;
        end else begin
            if (w_issue) begin
                r_req <= ~r_req;
                r_we  <= w_iss_we;
                r_a   <= w_iss_a[ADDR_W-1:1];
                r_ds  <= w_iss_a[0] ? 2'b10 : 2'b01;
                r_d   <= {w_iss_din, w_iss_din};
            end

            if (w_hit) begin
                r_dout <= w_cache_byte;
            end

            // Write-through keeps the cached word equal to SDRAM.
            if (w_wr && w_tag_match) begin
                if (cpu_a[0]) begin
                    r_cdata[15:8] <= cpu_din;
                end else begin
                    r_cdata[7:0]  <= cpu_din;
                end
            end

            case (r_state)
                S_DRAIN: begin
                    if (w_ack_eq) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (w_issue) begin
                        r_state <= w_iss_we ? S_WR_WAIT : S_RD_WAIT;
                        r_busy  <= ~w_iss_we;
                    end
                end
                S_WR_WAIT: begin
                    if (w_ack_eq) begin
                        r_pv <= 1'b0;
                        if (w_issue) begin
                            r_state <= w_iss_we ? S_WR_WAIT : S_RD_WAIT;
                            r_busy  <= ~w_iss_we;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_cpu_req) begin
                        r_pv   <= 1'b1;
                        r_pwe  <= w_wr;
                        r_pa   <= cpu_a;
                        r_pdin <= cpu_din;
                        r_busy <= 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    if (w_ack_eq) begin
                        r_ctag   <= r_a;
                        r_cdata  <= port_q;
                        r_cvalid <= CACHE_EN;
                        r_dout   <= r_ds[1] ? port_q[15:8] : port_q[7:0];
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_DRAIN;
                end
            endcase

            // Invalidate wins over a same-edge fill.
            if (cache_inv) begin
                r_cvalid <= 1'b0;
            end
        end
    end

    assign cpu_dout = r_dout;
    assign cpu_busy = r_busy;
    assign port_req = r_req;
    assign port_we  = r_we;
    assign port_a   = r_a;
    assign port_ds  = r_ds;
    assign port_d   = r_d;

endmodule
`default_nettype wire

// File: tb/tb_sdram_cpu_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_cpu_port
//  Description : Self-checking bench for sdram_cpu_port with a behavioural
//                SDRAM controller, memory and cache model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdram_cpu_port;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_rd = 1'b0, cpu_wr = 1'b0, cache_inv = 1'b0;
    logic [AW-1:0] cpu_a = '0;
    logic [7:0]    cpu_din = '0;
    logic [7:0]    cpu_dout;
    logic          cpu_busy;
    logic          port_req, port_we;
    logic          port_ack;
    logic [AW-2:0] port_a;
    logic [1:0]    port_ds;
    logic [15:0]   port_d, port_q;

    // second instance, cache disabled
    logic          cpu_rd2 = 1'b0;
    logic [AW-1:0] cpu_a2 = '0;
    logic [7:0]    cpu_dout2;
    logic          cpu_busy2, port_req2, port_we2;
    logic          port_ack2;
    logic [AW-2:0] port_a2;
    logic [1:0]    port_ds2;
    logic [15:0]   port_d2;
    logic [15:0]   port_q2;

    always #5 clk = ~clk;

    sdram_cpu_port #(.ADDR_W(AW), .CACHE_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_a(cpu_a), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .cpu_busy(cpu_busy), .cache_inv(cache_inv), .port_req(port_req),
        .port_ack(port_ack), .port_we(port_we), .port_a(port_a),
        .port_ds(port_ds), .port_d(port_d), .port_q(port_q)
    );

    sdram_cpu_port #(.ADDR_W(AW), .CACHE_EN(1'b0)) dut_nc (
        .clk(clk), .reset(reset), .cpu_rd(cpu_rd2), .cpu_wr(1'b0),
        .cpu_a(cpu_a2), .cpu_din(8'h00), .cpu_dout(cpu_dout2),
        .cpu_busy(cpu_busy2), .cache_inv(1'b0), .port_req(port_req2),
        .port_ack(port_ack2), .port_we(port_we2), .port_a(port_a2),
        .port_ds(port_ds2), .port_d(port_d2), .port_q(port_q2)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          we;
        logic [AW-2:0] a;
        logic [1:0]    ds;
        logic [15:0]   d;
    } txn_t;

    txn_t          exp_q[$];
    logic [15:0]   lmem [bit [AW-2:0]];   // memory as the CPU sees it
    logic [15:0]   pmem [bit [AW-2:0]];   // memory as the controller holds it
    bit            m_valid = 1'b0;
    logic [AW-2:0] m_tag = '0;

    function automatic logic [15:0] lget(input logic [AW-2:0] w);
        return lmem.exists(w) ? lmem[w] : 16'h0000;
    endfunction
    function automatic logic [15:0] pget(input logic [AW-2:0] w);
        return pmem.exists(w) ? pmem[w] : 16'h0000;
    endfunction

    // ---------------- controller model ----------------
    int   force_lat = 0;
    int   n_req = 0;
    int   n_b2b = 0;
    bit   outstanding = 1'b0;
    bit   just_acked = 1'b0;
    txn_t last_got;

    initial begin : ctrl
        txn_t got, e;
        int   lat;
        logic [15:0] v;
        port_ack = 1'b0;
        port_q   = 16'h0000;
        @(posedge clk); #1;
        port_ack = port_req;
        forever begin
            if (port_req !== port_ack) begin
                got = '{we: port_we, a: port_a, ds: port_ds, d: port_d};
                n_req++;
                if (just_acked) n_b2b++;
                just_acked = 1'b0;
                last_got = got;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req actual=%0h required=none", got);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_we", 32'(got.we), 32'(e.we));
                    chk("req_a", 32'(got.a), 32'(e.a));
                    chk("req_ds", 32'(got.ds), 32'(e.ds));
                    if (e.we) chk("req_d", 32'(got.d), 32'(e.d));
                end
                lat = (force_lat > 0) ? force_lat : $urandom_range(1, 5);
                outstanding = 1'b1;
                for (int i = 1; i < lat; i++) begin
                    @(posedge clk); #1;
                    chk("hold_ctl", 32'({port_req, port_we, port_ds}), 32'({~port_ack, got.we, got.ds}));
                    chk("hold_a", 32'(port_a), 32'(got.a));
                    chk("hold_d", 32'(port_d), 32'(got.d));
                end
                if (got.we) begin
                    v = pget(got.a);
                    if (got.ds[0]) v[7:0]  = got.d[7:0];
                    if (got.ds[1]) v[15:8] = got.d[15:8];
                    pmem[got.a] = v;
                end else begin
                    port_q = pget(got.a);
                end
                port_ack = ~port_ack;
                outstanding = 1'b0;
                just_acked = 1'b1;
            end else begin
                just_acked = 1'b0;
            end
            @(posedge clk); #1;
        end
    end

    // Fixed-latency controller for the cache-disabled instance.
    int n_req2 = 0;
    initial begin : ctrl2
        port_ack2 = 1'b0;
        port_q2   = 16'h7E81;
        @(posedge clk); #1;
        port_ack2 = port_req2;
        forever begin
            @(posedge clk); #1;
            if (port_req2 !== port_ack2) begin
                n_req2++;
                port_ack2 = port_req2;
            end
        end
    end

    // ---------------- driver tasks (phase: posedge + 2) ----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cpu_busy === 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("ready_timeout", 32'(n), 32'd0);
    endtask

    task automatic wait_quiet();
        int n = 0;
        do begin
            tick();
            n++;
        end while ((outstanding || exp_q.size() != 0 || cpu_busy) && n < 300);
        if (n >= 300) chk("quiet_timeout", 32'(n), 32'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input bit inv,
                           input bit wait_done, output int cycles);
        logic [AW-2:0] w;
        logic [15:0]   v;
        logic [7:0]    expb;
        bit            hit;
        wait_ready();
        w   = addr[AW-1:1];
        hit = m_valid && (m_tag == w) && !inv;
        if (!hit) exp_q.push_back('{we: 1'b0, a: w, ds: (addr[0] ? 2'b10 : 2'b01), d: 16'h0000});
        v    = lget(w);
        expb = addr[0] ? v[15:8] : v[7:0];
        m_valid = 1'b1;
        m_tag   = w;
        cpu_rd = 1'b1; cpu_a = addr; cpu_din = 8'($urandom); cache_inv = inv;
        tick();
        cpu_rd = 1'b0; cache_inv = 1'b0;
        cycles = 0;
        if (wait_done) begin
            while (cpu_busy && cycles < 300) begin
                tick();
                cycles++;
            end
            if (cycles >= 300) chk("rd_timeout", 32'(cycles), 32'd0);
            chk("rd_dout", 32'(cpu_dout), 32'(expb));
        end
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] din, input bit inv);
        logic [AW-2:0] w;
        logic [15:0]   v;
        wait_ready();
        w = addr[AW-1:1];
        exp_q.push_back('{we: 1'b1, a: w, ds: (addr[0] ? 2'b10 : 2'b01), d: {din, din}});
        v = lget(w);
        if (addr[0]) v[15:8] = din; else v[7:0] = din;
        lmem[w] = v;
        if (inv) m_valid = 1'b0;
        cpu_wr = 1'b1; cpu_a = addr; cpu_din = din; cache_inv = inv;
        tick();
        cpu_wr = 1'b0; cache_inv = 1'b0;
    endtask

    task automatic pulse_inv();
        cache_inv = 1'b1;
        tick();
        cache_inv = 1'b0;
        m_valid = 1'b0;
    endtask

    // Another master rewrites a word, then invalidates our cache.
    task automatic mutate(input logic [AW-2:0] w, input logic [15:0] val);
        wait_quiet();
        lmem[w] = val;
        pmem[w] = val;
        pulse_inv();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) a = a | 24'h800000;
        return a;
    endfunction

    // ---------------- main sequence ----------------
    initial begin : main
        int cyc, n0, nb, cnt, r;
        logic req0;
        logic [15:0] mv;

        lmem[23'h00091A] = 16'hA55A; pmem[23'h00091A] = 16'hA55A;
        lmem[23'h000080] = 16'h1357; pmem[23'h000080] = 16'h1357;

        // reset state
        repeat (3) tick();
        chk("reset_busy", 32'(cpu_busy), 32'd1);
        chk("reset_dout", 32'(cpu_dout), 32'hFF);
        chk("reset_busy_nc", 32'(cpu_busy2), 32'd1);
        reset = 1'b0;
        wait_ready();
        chk("drain_idle", 32'(cpu_busy), 32'd0);

        // 1: read miss with 6-cycle controller latency
        force_lat = 6;
        n0 = n_req;
        do_read(24'h001235, 1'b0, 1'b1, cyc);
        chk("t1_dout", 32'(cpu_dout), 32'hA5);
        chk("t1_busy_cycles", 32'(cyc), 32'd6);
        wait_quiet();
        chk("t1_one_req", 32'(n_req), 32'(n0 + 1));
        chk("t1_port_a", 32'(last_got.a), 32'h00091A);
        chk("t1_port_ds_we", 32'({last_got.ds, last_got.we}), 32'b100);
        force_lat = 0;

        // 2: hit on the other byte of the same word, then invalidate
        n0 = n_req;
        do_read(24'h001234, 1'b0, 1'b1, cyc);
        chk("t2_dout", 32'(cpu_dout), 32'h5A);
        chk("t2_hit_busy", 32'(cyc), 32'd0);
        wait_quiet();
        chk("t2_no_req", 32'(n_req), 32'(n0));
        pulse_inv();
        do_read(24'h001234, 1'b0, 1'b1, cyc);
        wait_quiet();
        chk("t2_inv_req", 32'(n_req), 32'(n0 + 1));

        // 3: posted write followed by a queued read miss
        force_lat = 4;
        nb = n_b2b;
        do_write(24'h000010, 8'h40, 1'b0);
        chk("t3_posted_busy", 32'(cpu_busy), 32'd0);
        chk("t3_wr_ds_d", 32'({port_ds, port_d}), 32'h14040);
        do_read(24'h000020, 1'b0, 1'b1, cyc);
        wait_quiet();
        chk("t3_back_to_back", 32'(n_b2b), 32'(nb + 1));
        force_lat = 0;

        // 4: write-through into the cached word
        do_read(24'h001235, 1'b0, 1'b1, cyc);
        wait_quiet();
        n0 = n_req;
        do_write(24'h001235, 8'hC3, 1'b0);
        do_read(24'h001235, 1'b0, 1'b1, cyc);
        chk("t4_dout", 32'(cpu_dout), 32'hC3);
        wait_quiet();
        chk("t4_only_write", 32'(n_req), 32'(n0 + 1));

        // 5: reset while a read is outstanding
        force_lat = 20;
        do_read(24'h000100, 1'b0, 1'b0, cyc);
        n0   = n_req;
        req0 = port_req;
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        chk("t5_rst_busy", 32'(cpu_busy), 32'd1);
        chk("t5_rst_req", 32'(port_req), 32'(req0));
        reset = 1'b0;
        tick();
        chk("t5_drain_dout", 32'(cpu_dout), 32'hFF);
        chk("t5_drain_busy", 32'(cpu_busy), 32'd1);
        cnt = 0;
        while (cpu_busy && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("t5_drain_done", 32'(cpu_busy), 32'd0);
        chk("t5_req_held", 32'(port_req), 32'(req0));
        chk("t5_dout_discard", 32'(cpu_dout), 32'hFF);
        m_valid = 1'b0;
        force_lat = 0;
        wait_quiet();
        chk("t5_no_extra", 32'(n_req), 32'(n0));
        do_read(24'h000100, 1'b0, 1'b1, cyc);
        chk("t5_reread_dout", 32'(cpu_dout), 32'h57);
        wait_quiet();
        chk("t5_reread_req", 32'(n_req), 32'(n0 + 1));

        // 6: cache disabled, same address read twice
        for (int k = 0; k < 2; k++) begin
            cnt = 0;
            while (cpu_busy2 && cnt < 50) begin tick(); cnt++; end
            cpu_rd2 = 1'b1; cpu_a2 = 24'h000003;
            tick();
            cpu_rd2 = 1'b0;
            cnt = 0;
            while (cpu_busy2 && cnt < 50) begin tick(); cnt++; end
            chk("t6_dout", 32'(cpu_dout2), 32'h7E);
        end
        chk("t6_two_reqs", 32'(n_req2), 32'd2);

        // random traffic
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      do_read(rand_addr(), 1'b0, 1'b1, cyc);
            else if (r < 55) do_read(rand_addr(), 1'b1, 1'b1, cyc);
            else if (r < 88) do_write(rand_addr(), 8'($urandom), 1'b0);
            else if (r < 94) do_write(rand_addr(), 8'($urandom), 1'b1);
            else begin
                mv = 16'($urandom);
                mutate(rand_addr() >> 1, mv);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_quiet();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
